// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// access-size encodings, byte-lane enables and request validation.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] byte_en(logic [2:0] f3, logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      F3_B:    be = 4'b0001 << a;
      F3_H:    be = a[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // A request is rejected for conflicting kinds, misalignment, unsigned
  // sizes used for stores, or an unknown size code.
  function automatic logic req_rejected(logic r, logic w, logic [1:0] a,
                                        logic [2:0] f3);
    logic e;
    e = r & w;
    case (f3)
      F3_B:    e = e;
      F3_H:    e = e | a[0];
      F3_W:    e = e | (a != 2'b00);
      F3_BU:   e = e | w;
      F3_HU:   e = e | w | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load-path lane select: picks the addressed byte or halfword out of a word
// and sign- or zero-extends it according to the access size.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_sel,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (byte_sel)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = byte_sel[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_W:    result = word;
      F3_BU:   result = {24'b0, lane_b};
      F3_HU:   result = {16'b0, lane_h};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, then performs the access and pulses ready.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  dmem_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        do_access;

  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_f3;
  logic [31:0]       req_wdata;
  logic              req_rd, req_wr, req_err, resp_err;

  logic [ADDR_W-1:0] op_addr;
  logic [2:0]        op_f3;
  logic [31:0]       op_wdata, wdata_lane, rd_word, load_val;
  logic              op_rd, op_wr, op_err;
  logic [3:0]        be;

  logic [31:0] mem [0:(2**(ADDR_W-2))-1];

  // With zero wait states the access happens on the accepting edge, so the
  // operands come straight from the inputs instead of the request latch.
  always_comb begin
    op_addr  = req_addr;
    op_f3    = req_f3;
    op_wdata = req_wdata;
    op_rd    = req_rd;
    op_wr    = req_wr;
    op_err   = req_err;
    if (state == IDLE) begin
      op_addr  = addr;
      op_f3    = funct3;
      op_wdata = wr_data;
      op_rd    = rd;
      op_wr    = wr;
      op_err   = req_rejected(rd, wr, addr[1:0], funct3);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (rd || wr) begin
          cnt_nxt = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            do_access = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
          do_access = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rd_data   <= '0;
      resp_err  <= 1'b0;
      req_addr  <= '0;
      req_f3    <= '0;
      req_wdata <= '0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && (rd || wr)) begin
        req_addr  <= addr;
        req_f3    <= funct3;
        req_wdata <= wr_data;
        req_rd    <= rd;
        req_wr    <= wr;
        req_err   <= req_rejected(rd, wr, addr[1:0], funct3);
      end
      if (do_access) begin
        resp_err <= op_err;
        if (op_rd) rd_data <= op_err ? '0 : load_val;
      end
    end
  end

  always_comb begin
    wdata_lane = op_wdata;
    case (op_f3[1:0])
      2'b00:   wdata_lane = {4{op_wdata[7:0]}};
      2'b01:   wdata_lane = {2{op_wdata[15:0]}};
      default: wdata_lane = op_wdata;
    endcase
  end

  assign be      = byte_en(op_f3, op_addr[1:0]);
  assign rd_word = mem[op_addr[ADDR_W-1:2]];

  // The array has no reset; gating with reset keeps an aborted store out.
  always_ff @(posedge clk) begin
    if (reset && do_access && op_wr && !op_err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[op_addr[ADDR_W-1:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
    end
  end

  dmem_load_ext u_load_ext (
    .word     (rd_word),
    .byte_sel (op_addr[1:0]),
    .funct3   (op_f3),
    .result   (load_val)
  );

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);
  assign err   = (state == RESP) && resp_err;

endmodule
